// File: rtl/adc_sample_writer_pkg.sv
// rtl/adc_sample_writer_pkg.sv - shared types and constants for the ADC sample writer
package adc_sample_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_WRITE
    } state_t;

    localparam int SAMPLE_W = 16;
    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;

    // LRCK level that marks a word of the given channel: left words arrive with LRCK high
    function automatic logic channel_lrck(input int channel);
        return (channel == CH_LEFT);
    endfunction

endpackage

// File: rtl/adc_sample_writer_sync_edge_detect.sv
// rtl/adc_sample_writer_sync_edge_detect.sv - multi-bit flop synchroniser with rising-edge pulse on bit 0
module adc_sample_writer_sync_edge_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_level,
    output logic             o_rise
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic             r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1][0];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1][0] & ~r_prev;

endmodule

// File: rtl/adc_sample_writer.sv
// rtl/adc_sample_writer.sv - records one I2S ADC channel into sample memory with start/stop control
module adc_sample_writer
    import adc_sample_writer_pkg::*;
#(
    parameter int                ADDR_W      = 18,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = {ADDR_W{1'b1}},
    parameter int                CHANNEL     = 0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_rec_start,
    input  logic                i_rec_stop,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_sample_rdy,
    input  logic                i_lrck,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [SAMPLE_W-1:0] o_mem_wdata,
    output logic                o_mem_wr_req,
    input  logic                i_mem_wr_ack,
    output logic                o_recording,
    output logic                o_mem_full,
    output logic                o_overrun,
    output logic [ADDR_W:0]     o_rec_len
);

    localparam logic ACCEPT_LRCK = channel_lrck(CHANNEL);

    logic [1:0] w_level;
    logic       w_rise;
    logic       w_event;

    // bit 0 carries the word strobe (edge used), bit 1 carries LRCK (level only)
    adc_sample_writer_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (2)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async ({i_lrck, i_sample_rdy}),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    assign w_event = w_rise && (w_level[1] == ACCEPT_LRCK);

    state_t                r_state;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [SAMPLE_W-1:0]   r_mem_wdata;
    logic                  r_mem_wr_req;
    logic                  r_recording;
    logic                  r_mem_full;
    logic                  r_overrun;
    logic [ADDR_W:0]       r_rec_len;
    logic                  r_stop_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wr_req <= 1'b0;
            r_recording  <= 1'b0;
            r_mem_full   <= 1'b0;
            r_overrun    <= 1'b0;
            r_rec_len    <= '0;
            r_stop_pend  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rec_start) begin
                        r_state     <= ST_ARMED;
                        r_recording <= 1'b1;
                        r_mem_addr  <= '0;
                        r_rec_len   <= '0;
                        r_mem_full  <= 1'b0;
                        r_overrun   <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end
                end
                // the first accepted word may have begun before start, so it is discarded
                ST_ARMED: begin
                    if (i_rec_stop) begin
                        r_state     <= ST_IDLE;
                        r_recording <= 1'b0;
                    end else if (w_event) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (i_rec_stop) begin
                        r_state     <= ST_IDLE;
                        r_recording <= 1'b0;
                    end else if (w_event) begin
                        r_mem_wdata  <= i_sample;
                        r_mem_wr_req <= 1'b1;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_event) begin
                        r_overrun <= 1'b1;
                    end
                    if (i_mem_wr_ack) begin
                        r_mem_wr_req <= 1'b0;
                        r_rec_len    <= r_rec_len + 1'b1;
                        r_stop_pend  <= 1'b0;
                        if (r_mem_addr == MAX_ADDR) begin
                            r_mem_full  <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_recording <= 1'b0;
                        end else begin
                            r_mem_addr <= r_mem_addr + 1'b1;
                            if (r_stop_pend || i_rec_stop) begin
                                r_state     <= ST_IDLE;
                                r_recording <= 1'b0;
                            end else begin
                                r_state <= ST_CAPTURE;
                            end
                        end
                    end else if (i_rec_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_recording  <= 1'b0;
                    r_mem_wr_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wr_req = r_mem_wr_req;
    assign o_recording  = r_recording;
    assign o_mem_full   = r_mem_full;
    assign o_overrun    = r_overrun;
    assign o_rec_len    = r_rec_len;

endmodule
